// File: rtl/simd_dmem_ctrl_if.sv
// Request/response bus of the SIMD data-memory controller.
// The requester uses the master modport and the memory controller uses the slave modport.
interface simd_dmem_ctrl_if #(
  parameter int LANES  = 8,
  parameter int ADDR_W = 14
);
  localparam int DW = 32 * LANES;
  localparam int BW = 4 * LANES;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [BW-1:0]     req_be;
  logic [DW-1:0]     req_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic              rsp_err;
  logic [DW-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/simd_dmem_ctrl.sv
// Single-port SIMD data memory with byte enables, a fixed read latency RD_LAT and one-cycle write responses.
// Defining DMEM_STATS_EN adds saturating rd_count/wr_count outputs for accepted requests.
module simd_dmem_ctrl #(
  parameter int LANES  = 8,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2 ** ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  simd_dmem_ctrl_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
`endif
);
  localparam int DW    = 32 * LANES;
  localparam int BW    = 4 * LANES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit MULTI_CYC = (RD_LAT > 1);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]      WAIT_INIT = 2'(RD_LAT - 2);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        cnt_r;
  logic [1:0]        cnt_nxt_s;
  logic              ready_r;
  logic              rsp_valid_r;
  logic              rsp_we_r;
  logic              rsp_err_r;
  logic [DW-1:0]     rsp_rdata_r;
  logic [DW-1:0]     hold_data_r;
  logic              hold_err_r;
  logic              ready_nxt_s;
  logic              rsp_valid_nxt_s;
  logic              rsp_we_nxt_s;
  logic              rsp_err_nxt_s;
  logic [DW-1:0]     rsp_rdata_nxt_s;
  logic              accept_s;
  logic              rd_accept_s;
  logic              in_range_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DW-1:0]     rd_word_s;
  logic [DW-1:0]     mem_r [DEPTH];

  assign accept_s    = bus.req_valid & ready_r;
  assign rd_accept_s = accept_s & ~bus.req_we;
  assign in_range_s  = ({1'b0, bus.req_addr} < DEPTH_L);
  assign idx_s       = bus.req_addr[IDX_W-1:0];
  assign wr_en_s     = accept_s & bus.req_we & in_range_s;
  // Out-of-range reads are forced to zero here so every read path inherits it
  assign rd_word_s   = in_range_s ? mem_r[idx_s] : '0;

  // State register and latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (rd_accept_s && MULTI_CYC) begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = WAIT_INIT;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 2'd0;
        end
      end
      RD_WAIT: begin
        if (cnt_r == 2'd0) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = cnt_r - 2'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // Output logic: values the response registers take at the next edge
  always_comb begin
    ready_nxt_s     = (state_nxt_s == IDLE);
    rsp_valid_nxt_s = 1'b0;
    rsp_we_nxt_s    = 1'b0;
    rsp_err_nxt_s   = 1'b0;
    rsp_rdata_nxt_s = '0;
    case (state_r)
      IDLE: begin
        if (accept_s && bus.req_we) begin
          rsp_valid_nxt_s = 1'b1;
          rsp_we_nxt_s    = 1'b1;
          rsp_err_nxt_s   = ~in_range_s;
        end else if (accept_s && !MULTI_CYC) begin
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = ~in_range_s;
          rsp_rdata_nxt_s = rd_word_s;
        end else begin
          rsp_valid_nxt_s = 1'b0;
        end
      end
      RD_WAIT: begin
        if (cnt_r == 2'd0) begin
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = hold_err_r;
          rsp_rdata_nxt_s = hold_data_r;
        end else begin
          rsp_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake and response outputs, plus the sampled read word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      hold_data_r <= '0;
      hold_err_r  <= 1'b0;
    end else begin
      ready_r     <= ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_we_r    <= rsp_we_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      if (rd_accept_s) begin
        hold_data_r <= rd_word_s;
        hold_err_r  <= ~in_range_s;
      end
    end
  end

  // Byte-enabled memory write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < BW; i++) begin
        if (bus.req_be[i]) begin
          mem_r[idx_s][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_we    = rsp_we_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_count_r;
  logic [31:0] wr_count_r;

  // Saturating counters of accepted requests, errored ones included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else begin
      if (rd_accept_s && (rd_count_r != 32'hFFFF_FFFF)) begin
        rd_count_r <= rd_count_r + 32'd1;
      end
      if (accept_s && bus.req_we && (wr_count_r != 32'hFFFF_FFFF)) begin
        wr_count_r <= wr_count_r + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;
`endif
endmodule

// File: tb/tb_simd_dmem_ctrl.sv
// Bench for simd_dmem_ctrl: three instances (RD_LAT 2, 1, 3; DEPTH 1024) checked every cycle
// against a memory/response-schedule model, plus hand-computed literal expectations.
module tb_simd_dmem_ctrl;
  localparam int LANES  = 8;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1024;
  localparam int DW     = 32 * LANES;
  localparam int BW     = 4 * LANES;
  localparam int NI     = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              vld [NI];
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BW-1:0]     be_d;
  logic [DW-1:0]     wd_d;
  logic              rdy  [NI];
  logic              rv   [NI];
  logic              rwe  [NI];
  logic              rerr [NI];
  logic [DW-1:0]     rdat [NI];
`ifdef DMEM_STATS_EN
  logic [31:0]       rdc_d [NI];
  logic [31:0]       wrc_d [NI];
  logic [31:0]       rdc_m [NI];
  logic [31:0]       wrc_m [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int RL = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    simd_dmem_ctrl_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus ();
    assign bus.req_valid = vld[g];
    assign bus.req_we    = we_d;
    assign bus.req_addr  = addr_d;
    assign bus.req_be    = be_d;
    assign bus.req_wdata = wd_d;
    assign rdy[g]  = bus.req_ready;
    assign rv[g]   = bus.rsp_valid;
    assign rwe[g]  = bus.rsp_we;
    assign rerr[g] = bus.rsp_err;
    assign rdat[g] = bus.rsp_rdata;
    simd_dmem_ctrl #(.LANES(LANES), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RL)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DMEM_STATS_EN
      ,
      .rd_count (rdc_d[g]),
      .wr_count (wrc_d[g])
`endif
    );
  end

  // Model: memory image, per-cycle response schedule (8 slots), busy-until cycle
  logic [DW-1:0] mm   [NI][DEPTH];
  bit            sv   [NI][8];
  bit            swe  [NI][8];
  bit            serr [NI][8];
  logic [DW-1:0] sdat [NI][8];
  int            busy [NI];
  int            rsp_seen [NI];
  logic [DW-1:0] last_rd [NI];
  int cyc = 0;
  int nchk = 0;
  int npass = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input int inst, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, inst, cyc, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int s;
      int slot;
      bit ev, ew, ee, er, inr;
      logic [DW-1:0] ed;
      s = cyc % 8;
      if (reset) begin
        for (int j = 0; j < 8; j++) sv[i][j] = 1'b0;
        busy[i] = 0;
        ev = 1'b0; ew = 1'b0; ee = 1'b0; ed = '0; er = 1'b1;
`ifdef DMEM_STATS_EN
        rdc_m[i] = 32'd0;
        wrc_m[i] = 32'd0;
`endif
      end else begin
        ev = sv[i][s]; ew = swe[i][s]; ee = serr[i][s];
        ed = ev ? sdat[i][s] : '0;
        sv[i][s] = 1'b0;
        er = (cyc >= busy[i]);
      end
      chk("req_ready", i, rdy[i], er);
      chk("rsp_valid", i, rv[i], ev);
      chk("rsp_we",    i, rwe[i], ev & ew);
      chk("rsp_err",   i, rerr[i], ev & ee);
      chk("rsp_rdata", i, rdat[i], ed);
`ifdef DMEM_STATS_EN
      chk("rd_count", i, rdc_d[i], rdc_m[i]);
      chk("wr_count", i, wrc_d[i], wrc_m[i]);
`endif
      if (rv[i] === 1'b1) begin
        rsp_seen[i]++;
        if (rwe[i] === 1'b0) last_rd[i] = rdat[i];
      end
      if (!reset && vld[i] && er) begin
        inr = (int'(addr_d) < DEPTH);
        if (we_d) begin
          if (inr) begin
            for (int b = 0; b < BW; b++)
              if (be_d[b]) mm[i][int'(addr_d)][8*b +: 8] = wd_d[8*b +: 8];
          end
          slot = (cyc + 1) % 8;
          sv[i][slot] = 1'b1; swe[i][slot] = 1'b1; serr[i][slot] = !inr; sdat[i][slot] = '0;
`ifdef DMEM_STATS_EN
          if (wrc_m[i] != 32'hFFFF_FFFF) wrc_m[i] = wrc_m[i] + 32'd1;
`endif
        end else begin
          slot = (cyc + lat_of(i)) % 8;
          sv[i][slot] = 1'b1; swe[i][slot] = 1'b0; serr[i][slot] = !inr;
          sdat[i][slot] = inr ? mm[i][int'(addr_d)] : '0;
          busy[i] = cyc + lat_of(i);
`ifdef DMEM_STATS_EN
          if (rdc_m[i] != 32'hFFFF_FFFF) rdc_m[i] = rdc_m[i] + 32'd1;
`endif
        end
      end
    end
  end

  task automatic do_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [BW-1:0] b, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    we_d = w; addr_d = a; be_d = b; wd_d = d; vld[i] = 1'b1;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if (rdy[i] === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    vld[i] = 1'b0;
    if (!done) begin
      nchk++;
      $display("FAIL handshake inst%0d: not accepted within 16 cycles, required accept", i);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] dpat, x1, x2, v0, v1, v2;
    logic [DW-1:0] ones, part;
    int c0, seen0;
    dpat = {4{64'h0123_4567_89AB_CDEF}};
    ones = '1;
    part = {{(DW-32){1'b1}}, 32'h0000_0000};
    x1 = {8{32'hA5A5_0001}};
    x2 = {8{32'h5A5A_0002}};
    v0 = {8{32'h1111_0000}};
    v1 = {8{32'h2222_0001}};
    v2 = {8{32'h3333_0002}};
    for (int i = 0; i < NI; i++) begin vld[i] = 1'b0; rsp_seen[i] = 0; last_rd[i] = '0; end
    we_d = 1'b0; addr_d = '0; be_d = '0; wd_d = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_ready", 0, rdy[0], 1'b1);
    chk("reset_valid", 0, rv[0], 1'b0);
    chk("reset_rdata", 0, rdat[0], '0);
    idle(2);
    reset = 1'b0;
    idle(1);

    // Full write then read of addr 5 on the RD_LAT=2 instance
    do_req(0, 1'b1, 14'd5, '1, dpat);
    do_req(0, 1'b0, 14'd5, '0, '0);
    @(negedge clk);
    chk("gap_ready", 0, rdy[0], 1'b0);
    @(negedge clk);
    chk("rd5_valid", 0, rv[0], 1'b1);
    chk("rd5_data", 0, rdat[0], dpat);
    idle(1);

    // Partial write on addr 7, zero-enable write, read-after-write next cycle
    do_req(0, 1'b1, 14'd7, '1, ones);
    do_req(0, 1'b1, 14'd7, 32'h0000_000F, '0);
    do_req(0, 1'b0, 14'd7, '0, '0);
    idle(3);
    chk("partial_rd", 0, last_rd[0], part);
    chk("partial_model", 0, mm[0][7], part);
    do_req(0, 1'b1, 14'd7, 32'h0000_0000, x2);
    do_req(0, 1'b0, 14'd7, '0, '0);
    idle(3);
    chk("be_zero_rd", 0, last_rd[0], part);

    // Out-of-range accesses with DEPTH 1024
    do_req(0, 1'b1, 14'd976, '1, x1);
    do_req(0, 1'b1, 14'd2000, '1, x2);
    do_req(0, 1'b0, 14'd1024, '0, '0);
    idle(3);
    chk("oor_rd_data", 0, last_rd[0], '0);
    do_req(0, 1'b0, 14'd976, '0, '0);
    idle(3);
    chk("alias_kept", 0, last_rd[0], x1);

    // RD_LAT=1: back-to-back reads
    do_req(1, 1'b1, 14'd0, '1, v0);
    do_req(1, 1'b1, 14'd1, '1, v1);
    do_req(1, 1'b1, 14'd2, '1, v2);
    idle(2);
    seen0 = rsp_seen[1];
    c0 = cyc;
    do_req(1, 1'b0, 14'd0, '0, '0);
    do_req(1, 1'b0, 14'd1, '0, '0);
    do_req(1, 1'b0, 14'd2, '0, '0);
    chk("b2b_cycles", 1, cyc - c0, 3);
    idle(2);
    chk("b2b_pulses", 1, rsp_seen[1] - seen0, 3);
    chk("b2b_last", 1, last_rd[1], v2);

    // RD_LAT=3: reset one cycle after a read accept aborts the read
    do_req(2, 1'b1, 14'd3, '1, x1);
    do_req(2, 1'b0, 14'd3, '0, '0);
    reset = 1'b1;
    seen0 = rsp_seen[2];
    idle(2);
    reset = 1'b0;
    idle(6);
    chk("abort_no_rsp", 2, rsp_seen[2] - seen0, 0);
    chk("abort_ready", 2, rdy[2], 1'b1);

    // Memory survives reset
    do_req(0, 1'b0, 14'd5, '0, '0);
    idle(3);
    chk("mem_kept", 0, last_rd[0], dpat);

`ifdef DMEM_STATS_EN
    do_req(2, 1'b1, 14'd10, '1, v0);
    do_req(2, 1'b1, 14'd11, '1, v1);
    do_req(2, 1'b1, 14'd2000, '1, v2);
    do_req(2, 1'b0, 14'd10, '0, '0);
    idle(3);
    do_req(2, 1'b0, 14'd1024, '0, '0);
    idle(4);
    chk("stats_wr3", 2, wrc_d[2], 32'd3);
    chk("stats_rd2", 2, rdc_d[2], 32'd2);
    force gen_dut[1].u_dut.wr_count_r = 32'hFFFF_FFFF;
    wrc_m[1] = 32'hFFFF_FFFF;
    #1;
    release gen_dut[1].u_dut.wr_count_r;
    do_req(1, 1'b1, 14'd20, '1, v0);
    idle(2);
    chk("stats_sat", 1, wrc_d[1], 32'hFFFF_FFFF);
`endif

    idle(2);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/simd_dmem_ctrl.md
SIMD_DMEM_CTRL -- requirements
Module: simd_dmem_ctrl

Interface
REQ-001 Parameter LANES, default 8: number of 32-bit lanes; data width DW = 32*LANES, byte-enable width BW = 4*LANES.
REQ-002 Parameter ADDR_W, default 14: word-address width.
REQ-003 Parameter DEPTH, default 2**ADDR_W: number of DW-bit words stored; DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 2: read latency in cycles; legal range 1..4.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  word address.
REQ-011 req_be  in  BW  byte enables; bit i governs req_wdata[8i+7:8i].
REQ-012 req_wdata  in  DW  write data.
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_we  out  1  response belongs to a write.
REQ-015 rsp_err  out  1  request address was >= DEPTH.
REQ-016 rsp_rdata  out  DW  read data; zero for write responses.

Function
REQ-017 The state machine SHALL have states IDLE and RD_WAIT; req_ready = 1 in IDLE, 0 in RD_WAIT, except in the response cycle (see REQ-020).
REQ-018 An accepted write (cycle 0) SHALL update enabled bytes at the end of cycle 0, leave disabled bytes unchanged, keep state IDLE, and produce rsp_valid=1, rsp_we=1 in cycle 1.
REQ-019 An accepted read (cycle 0) SHALL move to RD_WAIT, load a latency counter, and sample memory at the end of cycle 0.
REQ-020 The read response SHALL appear exactly in cycle RD_LAT (rsp_valid=1, rsp_we=0); the state machine SHALL return to IDLE so req_ready=1 in that cycle, allowing a new request there.
REQ-021 With RD_LAT=1, back-to-back reads SHALL be accepted every cycle, with no bubble.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-023 Address >= DEPTH: writes SHALL be dropped; reads SHALL return zero; both responses SHALL carry rsp_err=1.
REQ-024 req_valid while req_ready=0 SHALL be ignored, with no state change; requesters hold the request until accepted.
REQ-025 Outside response cycles, rsp_valid, rsp_we and rsp_err SHALL be 0, and rsp_rdata SHALL be 0.
REQ-026 A write with req_be all zero SHALL leave memory unchanged and still respond.

Reset
REQ-027 While reset is high, the block SHALL force: state IDLE, req_ready=1, rsp_valid=0, rsp_we=0, rsp_err=0, rsp_rdata=0, and counters (REQ-030) to zero.
REQ-028 Reset asserted mid-read SHALL abort the read; no rsp_valid is produced for it.
REQ-029 Memory contents SHALL NOT be reset.

Configuration
REQ-030 With macro DMEM_STATS_EN defined, the block SHALL add outputs rd_count[31:0] and wr_count[31:0].
  - Each counter increments on every accepted read or write respectively, including errored requests.
  - Each counter saturates at 32'hFFFF_FFFF.
REQ-031 Without DMEM_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 LANES=8, RD_LAT=2: write addr 5, be=all-ones, data=256'h0123..CDEF -> rsp_valid 1 cycle later with rsp_we=1; read addr 5 -> rsp_valid 2 cycles after accept, rdata=256'h0123..CDEF; req_ready=0 in the cycle between.
REQ-033 Partial write:
  - Setup: addr 7 holds all-ones; write data 0 with be=32'h0000_000F.
  - Response: a subsequent read of addr 7 returns all-ones with bits 31:0 = 0.
REQ-034 RD_LAT=1: reads of addr 0,1,2 on consecutive cycles -> three consecutive rsp_valid pulses with matching data, and req_ready held 1.
REQ-035 DEPTH=1024: read addr 1024 -> rdata=0, rsp_err=1; write addr 2000 -> rsp_err=1, and addr 2000 mod 1024 remains unchanged.
REQ-036 Assert reset one cycle after a read accept with RD_LAT=3 -> no rsp_valid afterwards; req_ready=1 once reset is released.
REQ-037 DMEM_STATS_EN defined: 3 writes + 2 reads -> wr_count=3, rd_count=2; a preloaded wr_count of 32'hFFFF_FFFF stays saturated after a further write.
